// File: rtl/aes_ahb_mover_if.sv
// rtl/aes_ahb_mover_if.sv - AHB-lite bus bundle between the AES data mover and SRAM
//
// Purpose: groups the AHB-lite address/data/response signals of one
//          single-master link so the mover and its slave share one port.
// Ports (modport master = mover side, slave = SRAM side):
//   haddr[31:0], htrans[1:0], hwrite, hsize[2:0], hwdata[31:0] : master -> slave
//   hrdata[31:0], hready, hresp                               : slave  -> master
interface aes_ahb_mover_if;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/aes_ahb_mover.sv
// rtl/aes_ahb_mover.sv - AHB-lite master moving 128-bit AES blocks to/from SRAM
//
// Purpose: on a shift request, reads one 128-bit block from SRAM (mode=1) or
//          writes one 128-bit block to SRAM (mode=0) as four 32-bit single
//          NONSEQ transfers; tracks src/dst pointers and the blocks-read count.
// Ports:
//   clk, n_rst                      clock, asynchronous active-low reset
//   cfg_load, cfg_src_addr,
//   cfg_dst_addr, cfg_num_blocks    job configuration, latched only when idle
//   shift_en, mode, wr_block        transfer request from the AES controller
//   rd_block, rd_valid              assembled read block and its update pulse
//   wr_done                         write-block completion pulse
//   busy, last_round, err           status (err is sticky until cfg_load)
//   ahb                             AHB-lite master bus
module aes_ahb_mover #(
    parameter int NUM_BLK_W = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 cfg_load,
    input  logic [31:0]          cfg_src_addr,
    input  logic [31:0]          cfg_dst_addr,
    input  logic [NUM_BLK_W-1:0] cfg_num_blocks,
    input  logic                 shift_en,
    input  logic                 mode,
    input  logic [127:0]         wr_block,
    output logic [127:0]         rd_block,
    output logic                 rd_valid,
    output logic                 wr_done,
    output logic                 busy,
    output logic                 last_round,
    output logic                 err,
    aes_ahb_mover_if.master      ahb
);
    localparam int          WORDS     = 4;
    localparam logic [1:0]  LAST_BEAT = 2'(WORDS - 1);
    localparam logic [1:0]  HT_IDLE   = 2'b00;
    localparam logic [1:0]  HT_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FINISH} state_t;

    state_t                 state_q;
    logic                   mode_q;
    logic [1:0]             beat_q;
    logic [31:0]            src_ptr_q, dst_ptr_q;
    logic [NUM_BLK_W-1:0]   num_blocks_q, blocks_read_q;
    logic [127:0]           wr_buf_q, rd_block_q;
    logic                   rd_valid_q, wr_done_q, err_q;
    logic [31:0]            haddr_q, hwdata_q;
    logic [1:0]             htrans_q;
    logic                   hwrite_q;

    logic [31:0]            start_addr_d;
    logic [31:0]            wr_word_d;

    // A cfg_load coinciding with the request is honoured, so the first beat
    // must already use the freshly loaded base address.
    assign start_addr_d = mode ? (cfg_load ? cfg_src_addr : src_ptr_q)
                               : (cfg_load ? cfg_dst_addr : dst_ptr_q);
    assign wr_word_d    = wr_buf_q[{beat_q, 5'b0} +: 32];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            beat_q        <= '0;
            src_ptr_q     <= '0;
            dst_ptr_q     <= '0;
            num_blocks_q  <= '0;
            blocks_read_q <= '0;
            wr_buf_q      <= '0;
            rd_block_q    <= '0;
            rd_valid_q    <= 1'b0;
            wr_done_q     <= 1'b0;
            err_q         <= 1'b0;
            haddr_q       <= '0;
            htrans_q      <= HT_IDLE;
            hwrite_q      <= 1'b0;
            hwdata_q      <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_load) begin
                        src_ptr_q     <= cfg_src_addr;
                        dst_ptr_q     <= cfg_dst_addr;
                        num_blocks_q  <= cfg_num_blocks;
                        blocks_read_q <= '0;
                        err_q         <= 1'b0;
                    end
                    if (shift_en) begin
                        state_q  <= S_ADDR;
                        mode_q   <= mode;
                        beat_q   <= '0;
                        htrans_q <= HT_NONSEQ;
                        haddr_q  <= start_addr_d;
                        hwrite_q <= ~mode;
                        if (!mode) begin
                            wr_buf_q <= wr_block;
                        end
                    end
                end
                S_ADDR: begin
                    if (ahb.hready) begin
                        state_q  <= S_DATA;
                        htrans_q <= HT_IDLE;
                        if (!mode_q) begin
                            hwdata_q <= wr_word_d;
                        end
                    end
                end
                S_DATA: begin
                    if (ahb.hresp) begin
                        // Abort: the block is abandoned without advancing
                        // pointers or counters.
                        err_q    <= 1'b1;
                        state_q  <= S_IDLE;
                        hwrite_q <= 1'b0;
                    end else if (ahb.hready) begin
                        if (mode_q) begin
                            rd_block_q[{beat_q, 5'b0} +: 32] <= ahb.hrdata;
                        end
                        if (beat_q == LAST_BEAT) begin
                            // Pulses and bookkeeping land together so they
                            // are visible in the FINISH cycle.
                            state_q  <= S_FINISH;
                            hwrite_q <= 1'b0;
                            if (mode_q) begin
                                rd_valid_q <= 1'b1;
                                src_ptr_q  <= src_ptr_q + 32'd16;
                                if (blocks_read_q != '1) begin
                                    blocks_read_q <= blocks_read_q + 1'b1;
                                end
                            end else begin
                                wr_done_q <= 1'b1;
                                dst_ptr_q <= dst_ptr_q + 32'd16;
                            end
                        end else begin
                            beat_q   <= beat_q + 2'd1;
                            state_q  <= S_ADDR;
                            htrans_q <= HT_NONSEQ;
                            haddr_q  <= haddr_q + 32'd4;
                        end
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_block   = rd_block_q;
    assign rd_valid   = rd_valid_q;
    assign wr_done    = wr_done_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);
    assign last_round = (blocks_read_q == num_blocks_q);

    assign ahb.haddr  = haddr_q;
    assign ahb.htrans = htrans_q;
    assign ahb.hwrite = hwrite_q;
    assign ahb.hsize  = 3'b010;
    assign ahb.hwdata = hwdata_q;
endmodule

// File: doc/aes_ahb_mover.md
Name: aes_ahb_mover

Overview:
- AHB-lite master data mover that services the AES controller's shift requests.
- Read mode (mode=1): fetches one 128-bit plaintext/ciphertext block from SRAM as four 32-bit single transfers and presents it to the AES datapath.
- Write mode (mode=0): stores one 128-bit result block back to SRAM.
- Tracks source/destination addresses and block count, and drives last_round back to the controller.

Parameters:
- NUM_BLK_W, 16, width of the block-count field.
- WORDS, 4, 32-bit beats per block; fixed, not configurable in this revision.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous, active-low reset.
- cfg_load  in  1  single-cycle pulse that latches the three cfg_* fields below.
- cfg_src_addr  in  32  word-aligned SRAM read base address.
- cfg_dst_addr  in  32  word-aligned SRAM write base address.
- cfg_num_blocks  in  NUM_BLK_W  number of 128-bit blocks in the job.
- shift_en  in  1  transfer request from controller (ahb_shift_en).
- mode  in  1  1 = read from SRAM, 0 = write to SRAM (ahb_mode).
- wr_block  in  128  block to write; sampled on the accepted shift_en cycle.
- rd_block  out  128  assembled read block.
- rd_valid  out  1  one-cycle pulse when rd_block is updated.
- wr_done  out  1  one-cycle pulse when all four write beats complete.
- busy  out  1  high while any transfer is in progress.
- last_round  out  1  high when blocks_read == num_blocks.
- err  out  1  sticky AHB error flag; cleared by cfg_load.
- haddr  out  32  AHB address.
- htrans  out  2  AHB transfer type (IDLE=2'b00, NONSEQ=2'b10).
- hwrite  out  1  AHB write.
- hsize  out  3  AHB size; constant 3'b010.
- hwdata  out  32  AHB write data.
- hrdata  in  32  AHB read data.
- hready  in  1  AHB ready.
- hresp  in  1  AHB response; 1 = ERROR.

Behaviour:
- Reset: state IDLE. All counters and address pointers = 0. rd_block = 0. haddr = 0, htrans = IDLE, hwrite = 0, hwdata = 0. rd_valid, wr_done, busy, err = 0. last_round = 1, because 0 blocks read == 0 configured.
- cfg_load in IDLE:
  - src_ptr <= cfg_src_addr, dst_ptr <= cfg_dst_addr, num_blocks <= cfg_num_blocks.
  - blocks_read <= 0, err <= 0.
  - cfg_load while busy is ignored.
- last_round is combinational from registers: (blocks_read == num_blocks). cfg_num_blocks = 0 gives last_round = 1 immediately after load.
- States:
  - IDLE
  - ADDR: htrans = NONSEQ, haddr = ptr + 4*beat, hwrite = ~mode_q.
  - DATA: htrans = IDLE; hwdata = wr_buf word[beat] when writing.
  - FINISH
- Transitions:
  - IDLE -> ADDR when shift_en = 1. Latch mode_q = mode, beat = 0; latch wr_buf = wr_block if mode = 0.
  - shift_en outside IDLE is ignored, with no queueing.
  - ADDR -> DATA when hready = 1; hold ADDR while hready = 0.
  - DATA with hready = 1 and hresp = 0:
    - read: capture hrdata into rd_block[32*beat+31 : 32*beat] (word 0 = lowest address, bits [31:0]).
    - if beat == 3 go to FINISH, else beat++ and go to ADDR.
  - DATA with hready = 0: hold; hwdata is stable across wait states.
  - DATA with hresp = 1 (sampled on any cycle): err <= 1, go to IDLE. Pointers and blocks_read are not advanced; no rd_valid or wr_done.
  - FINISH:
    - read: pulse rd_valid, src_ptr += 16, blocks_read++.
    - write: pulse wr_done, dst_ptr += 16.
    - FINISH -> IDLE.
- busy = (state != IDLE).
- Latency with a zero-wait slave: shift_en sampled at edge 0 -> first NONSEQ at cycle 1. Each beat is 2 cycles. rd_valid or wr_done is high in cycle 9.
- Wrap-around:
  - Pointers are 32-bit modulo; no boundary checks.
  - blocks_read saturates at its maximum value. Reads beyond num_blocks are still performed; last_round stays 0 after overshoot.
- Async reset mid-transfer: htrans returns to IDLE immediately and partial block data is discarded.

Test Plan:
- Load src=0x100, dst=0x200, n=2. Two read requests on a zero-wait slave -> haddr 0x100, 0x104, 0x108, 0x10C then 0x110..0x11C. rd_block = {w3,w2,w1,w0}. rd_valid at cycle 9 each time. last_round = 1 after the second read.
- Write request with wr_block = 128'h0123..CDEF and dst=0x200 -> four writes to 0x200..0x20C carrying the words low-first. wr_done pulses once. dst_ptr = 0x210.
- hready low for 3 cycles in beat 2's data phase -> hwdata and state held. Completion is delayed by exactly 3 cycles. Data is still correct.
- hresp = 1 on beat 1 of a read -> err = 1, return to IDLE, no rd_valid, blocks_read unchanged. A following cfg_load clears err.
- cfg_num_blocks = 0 -> last_round = 1 right after load. cfg_load and shift_en issued while busy -> both ignored.
- n_rst asserted during beat 1 -> all outputs return to their reset values asynchronously, and the next request starts cleanly.
